// File: rtl/systolic_pkg.sv
// Shared types and helpers for the weight-stationary systolic array.
// State encoding for the weight-load FSM and pipeline latency.
package systolic_pkg;

  typedef enum logic [1:0] {
    LOAD,
    RUN,
    DRAIN
  } state_t;

  function automatic int lat(input int num_row, input int num_col);
    return num_row + num_col - 1;
  endfunction

endpackage

// File: rtl/pe_mac.sv
// One processing element: stationary weight, registered activation
// pass-through and registered partial sum.
module pe_mac #(
  parameter int IN_WORD_SIZE  = 8,
  parameter int OUT_WORD_SIZE = 24,
  parameter int SIGNED        = 1
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     en,
  input  logic                     w_we,
  input  logic [IN_WORD_SIZE-1:0]  w_i,
  input  logic [IN_WORD_SIZE-1:0]  act_i,
  input  logic [OUT_WORD_SIZE-1:0] psum_i,
  output logic [IN_WORD_SIZE-1:0]  act_o,
  output logic [OUT_WORD_SIZE-1:0] psum_o
);

  localparam int  IW = IN_WORD_SIZE;
  localparam int  OW = OUT_WORD_SIZE;
  localparam int  XW = OW - IW;
  localparam bit  SX = (SIGNED != 0);

  logic [IW-1:0] w_q;
  logic [OW-1:0] a_x;
  logic [OW-1:0] w_x;
  logic [OW-1:0] prod;

  // Extending to the result width first makes the wrap come out right.
  assign a_x  = {{XW{SX & act_i[IW-1]}}, act_i};
  assign w_x  = {{XW{SX & w_q[IW-1]}}, w_q};
  assign prod = a_x * w_x;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      w_q <= '0;
    end else if (w_we) begin
      w_q <= w_i;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      act_o  <= '0;
      psum_o <= '0;
    end else if (en) begin
      act_o  <= act_i;
      psum_o <= psum_i + prod;
    end
  end

endmodule

// File: rtl/systolic_array_ws.sv
// Weight-stationary systolic MAC array with weight-load FSM,
// input skew, output deskew and valid/ready handshakes.
module systolic_array_ws
  import systolic_pkg::*;
#(
  parameter int IN_WORD_SIZE  = 8,
  parameter int OUT_WORD_SIZE = 24,
  parameter int NUM_ROW       = 8,
  parameter int NUM_COL       = 8,
  parameter int SIGNED        = 1
) (
  input  logic                             clk,
  input  logic                             reset_n,
  input  logic                             w_load_valid,
  output logic                             w_load_ready,
  input  logic [IN_WORD_SIZE*NUM_COL-1:0]  w_row_i,
  input  logic                             in_valid,
  output logic                             in_ready,
  input  logic [IN_WORD_SIZE*NUM_ROW-1:0]  input_i,
  output logic                             out_valid,
  output logic [OUT_WORD_SIZE*NUM_COL-1:0] result_o
);

  localparam int IW = IN_WORD_SIZE;
  localparam int OW = OUT_WORD_SIZE;
  localparam int L  = lat(NUM_ROW, NUM_COL);
  localparam int CW = $clog2(L + 1);
  localparam int RW = $clog2(NUM_ROW);

  state_t state, state_nx;

  logic [RW-1:0] w_cnt;
  logic [CW-1:0] inflight;
  logic [L-1:0]  vs;
  logic          en, accept, w_acc, dec;

  logic [IW-1:0] inj  [NUM_ROW];
  logic [IW-1:0] act  [NUM_ROW][NUM_COL+1];
  logic [OW-1:0] psum [NUM_ROW+1][NUM_COL];
  logic [OW*NUM_COL-1:0] dsk;
  logic [NUM_ROW-1:0]    unused_act;

  assign en     = (state != LOAD);
  assign accept = in_valid & in_ready;
  assign w_acc  = w_load_valid & w_load_ready;
  assign dec    = en & vs[L-1];

  always_comb begin
    state_nx     = state;
    w_load_ready = 1'b0;
    in_ready     = 1'b0;
    unique case (state)
      LOAD: begin
        w_load_ready = 1'b1;
        if (w_load_valid && w_cnt == RW'(NUM_ROW - 1))
          state_nx = RUN;
      end
      RUN: begin
        in_ready = !w_load_valid;
        if (w_load_valid)
          state_nx = DRAIN;
      end
      DRAIN: begin
        if (inflight == '0)
          state_nx = LOAD;
      end
      default: state_nx = LOAD;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state    <= LOAD;
      w_cnt    <= '0;
      inflight <= '0;
    end else begin
      state    <= state_nx;
      inflight <= inflight + CW'(accept) - CW'(dec);
      if (w_acc)
        w_cnt <= (w_cnt == RW'(NUM_ROW - 1)) ? '0 : w_cnt + 1'b1;
    end
  end

  for (genvar r = 0; r < NUM_ROW; r++) begin : g_row
    // Idle cycles push zeros so stale activations never re-enter.
    assign inj[r] = accept ? input_i[IW*r +: IW] : '0;

    if (r == 0) begin : g_noskew
      assign act[0][0] = inj[0];
    end else begin : g_skew
      logic [IW-1:0] sk [r];
      always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
          for (int k = 0; k < r; k++) sk[k] <= '0;
        end else if (en) begin
          sk[0] <= inj[r];
          for (int k = 1; k < r; k++) sk[k] <= sk[k-1];
        end
      end
      assign act[r][0] = sk[r-1];
    end

    assign unused_act[r] = ^act[r][NUM_COL];

    for (genvar c = 0; c < NUM_COL; c++) begin : g_col
      pe_mac #(
        .IN_WORD_SIZE (IW),
        .OUT_WORD_SIZE(OW),
        .SIGNED       (SIGNED)
      ) u_pe (
        .clk    (clk),
        .reset_n(reset_n),
        .en     (en),
        .w_we   (w_acc && (w_cnt == RW'(r))),
        .w_i    (w_row_i[IW*c +: IW]),
        .act_i  (act[r][c]),
        .psum_i (psum[r][c]),
        .act_o  (act[r][c+1]),
        .psum_o (psum[r+1][c])
      );
    end
  end

  for (genvar c = 0; c < NUM_COL; c++) begin : g_dsk
    localparam int D = NUM_COL - 1 - c;
    assign psum[0][c] = '0;
    if (D == 0) begin : g_nodly
      assign dsk[OW*c +: OW] = psum[NUM_ROW][c];
    end else begin : g_dly
      logic [OW-1:0] dq [D];
      always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
          for (int k = 0; k < D; k++) dq[k] <= '0;
        end else if (en) begin
          dq[0] <= psum[NUM_ROW][c];
          for (int k = 1; k < D; k++) dq[k] <= dq[k-1];
        end
      end
      assign dsk[OW*c +: OW] = dq[D-1];
    end
  end

  // out_valid is cleared even while the datapath is frozen in LOAD.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      vs        <= '0;
      out_valid <= 1'b0;
      result_o  <= '0;
    end else begin
      if (en)
        vs <= {vs[L-2:0], accept};
      out_valid <= dec;
      if (dec)
        result_o <= dsk;
    end
  end

endmodule

// File: tb/tb_systolic_array_ws.sv
// Directed + random bench for systolic_array_ws against a
// queue-based dot-product reference model.
module tb_systolic_array_ws;

  localparam int R = 8;
  localparam int C = 8;
  localparam int L = R + C - 1;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic w_load_valid = 1'b0;
  logic in_valid = 1'b0;
  logic [8*C-1:0] w_row_i = '0;
  logic [8*R-1:0] input_i = '0;

  logic w_load_ready, in_ready, out_valid;
  logic [24*C-1:0] result_o;
  logic w_load_ready_u, in_ready_u, out_valid_u;
  logic [16*C-1:0] result_u;

  always #5 clk = ~clk;

  systolic_array_ws #(
    .IN_WORD_SIZE(8), .OUT_WORD_SIZE(24),
    .NUM_ROW(R), .NUM_COL(C), .SIGNED(1)
  ) u_dut (
    .clk(clk), .reset_n(reset_n),
    .w_load_valid(w_load_valid), .w_load_ready(w_load_ready),
    .w_row_i(w_row_i),
    .in_valid(in_valid), .in_ready(in_ready),
    .input_i(input_i),
    .out_valid(out_valid), .result_o(result_o)
  );

  systolic_array_ws #(
    .IN_WORD_SIZE(8), .OUT_WORD_SIZE(16),
    .NUM_ROW(R), .NUM_COL(C), .SIGNED(0)
  ) u_dut_u (
    .clk(clk), .reset_n(reset_n),
    .w_load_valid(w_load_valid), .w_load_ready(w_load_ready_u),
    .w_row_i(w_row_i),
    .in_valid(in_valid), .in_ready(in_ready_u),
    .input_i(input_i),
    .out_valid(out_valid_u), .result_o(result_u)
  );

  typedef struct {
    logic [24*C-1:0] e24;
    logic [16*C-1:0] e16;
    int              due;
  } exp_t;

  exp_t q[$];
  logic [7:0]   wm [R][C];
  logic [8*C-1:0] wrow [R];
  logic [24*C-1:0] last24;
  logic [16*C-1:0] last16;
  int mode, beats, cyc;
  int n_asr = 0;
  int n_fail = 0;

  task automatic chk(string tag, logic [191:0] obs, logic [191:0] exp_v);
    n_asr++;
    assert (obs === exp_v) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
    end
  endtask

  function automatic logic [24*C-1:0] calc24(logic [8*R-1:0] v);
    logic [24*C-1:0] res;
    longint s;
    res = '0;
    for (int c = 0; c < C; c++) begin
      s = 0;
      for (int r = 0; r < R; r++)
        s += longint'($signed(v[8*r +: 8])) * longint'($signed(wm[r][c]));
      res[24*c +: 24] = s[23:0];
    end
    return res;
  endfunction

  function automatic logic [16*C-1:0] calc16(logic [8*R-1:0] v);
    logic [16*C-1:0] res;
    longint s;
    res = '0;
    for (int c = 0; c < C; c++) begin
      s = 0;
      for (int r = 0; r < R; r++)
        s += longint'(v[8*r +: 8]) * longint'(wm[r][c]);
      res[16*c +: 16] = s[15:0];
    end
    return res;
  endfunction

  task automatic model_clear();
    q.delete();
    mode = 0;
    beats = 0;
    last24 = '0;
    last16 = '0;
    for (int r = 0; r < R; r++)
      for (int c = 0; c < C; c++) wm[r][c] = '0;
  endtask

  // One clock: check handshakes, advance the model, check outputs.
  task automatic tick();
    bit exp_wr, exp_ir, acc, wacc, drained, ev;
    #1;
    exp_wr  = (mode == 0);
    exp_ir  = (mode == 1) && !w_load_valid;
    drained = (q.size() == 0);
    chk("w_load_ready", w_load_ready, exp_wr);
    chk("in_ready", in_ready, exp_ir);
    chk("w_load_ready_u", w_load_ready_u, exp_wr);
    chk("in_ready_u", in_ready_u, exp_ir);
    acc  = in_valid && exp_ir;
    wacc = w_load_valid && exp_wr;
    @(posedge clk);
    cyc++;
    if (acc)
      q.push_back('{e24: calc24(input_i), e16: calc16(input_i),
                    due: cyc + L});
    case (mode)
      0: if (wacc) begin
        for (int c = 0; c < C; c++) wm[beats][c] = w_row_i[8*c +: 8];
        if (beats == R - 1) begin
          beats = 0;
          mode = 1;
        end else begin
          beats++;
        end
      end
      1: if (w_load_valid) mode = 2;
      default: if (drained) mode = 0;
    endcase
    @(negedge clk);
    ev = (q.size() > 0) && (q[0].due == cyc);
    chk("out_valid", out_valid, ev);
    chk("out_valid_u", out_valid_u, ev);
    if (ev) begin
      last24 = q[0].e24;
      last16 = q[0].e16;
      void'(q.pop_front());
    end
    chk("result", result_o, last24);
    chk("result_u", result_u, last16);
  endtask

  task automatic send(logic [8*R-1:0] v);
    in_valid = 1'b1;
    input_i = v;
    tick();
    in_valid = 1'b0;
  endtask

  task automatic idle(int n);
    in_valid = 1'b0;
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic load();
    if (mode == 1) begin
      w_load_valid = 1'b1;
      tick();
      w_load_valid = 1'b0;
    end
    for (int i = 0; i < 4 * L && mode != 0; i++) tick();
    for (int r = 0; r < R; r++) begin
      w_load_valid = 1'b1;
      w_row_i = wrow[r];
      tick();
    end
    w_load_valid = 1'b0;
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    #1;
    chk("rst_out_valid", out_valid, 1'b0);
    chk("rst_result", result_o, '0);
    chk("rst_w_load_ready", w_load_ready, 1'b1);
    chk("rst_in_ready", in_ready, 1'b0);
    chk("rst_result_u", result_u, '0);
    model_clear();
    @(posedge clk);
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  function automatic logic [63:0] rnd64();
    return {$urandom(), $urandom()};
  endfunction

  logic [8*R-1:0] v;

  initial begin
    cyc = 0;
    model_clear();
    repeat (2) @(negedge clk);
    do_reset();

    // identity weights, input r+1 -> result c+1
    for (int r = 0; r < R; r++) begin
      wrow[r] = '0;
      wrow[r][8*r +: 8] = 8'd1;
    end
    load();
    for (int r = 0; r < R; r++) v[8*r +: 8] = 8'(r + 1);
    send(v);
    idle(L + 2);

    // all weights 0xFF, inputs 127 then 0xFF
    for (int r = 0; r < R; r++) wrow[r] = {C{8'hFF}};
    load();
    send({R{8'd127}});
    idle(L + 2);
    send({R{8'hFF}});
    idle(L + 2);

    // 4 back-to-back, 2-cycle gap, 2 more
    for (int r = 0; r < R; r++) wrow[r] = rnd64();
    load();
    for (int i = 0; i < 4; i++) send(rnd64());
    idle(2);
    for (int i = 0; i < 2; i++) send(rnd64());
    idle(L + 2);

    // reload request with 3 in flight and a competing input
    for (int i = 0; i < 3; i++) send(rnd64());
    in_valid = 1'b1;
    w_load_valid = 1'b1;
    input_i = rnd64();
    tick();
    in_valid = 1'b0;
    w_load_valid = 1'b0;
    for (int r = 0; r < R; r++) wrow[r] = rnd64();
    load();
    send(rnd64());
    idle(L + 2);

    // random stream with gaps
    for (int i = 0; i < 24; i++) begin
      if ($urandom_range(0, 3) == 0) idle(1);
      send(rnd64());
    end
    idle(L + 2);

    // reset with 5 in flight, then inputs blocked until reload
    for (int i = 0; i < 5; i++) send(rnd64());
    do_reset();
    in_valid = 1'b1;
    input_i = rnd64();
    for (int i = 0; i < L + 3; i++) tick();
    for (int r = 0; r < R; r++) wrow[r] = rnd64();
    load();
    in_valid = 1'b0;
    send(rnd64());
    send(rnd64());
    idle(L + 2);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_asr, n_fail);
    $finish;
  end

endmodule

// File: doc/systolic_array_ws.md
Name: systolic_array_ws

Overview:
Parametrised weight-stationary systolic MAC array, the successor to the fixed 16x16 array. It adds four things the fixed array lacks: an on-block weight-load FSM, an input skew buffer, an output deskew buffer and a valid/ready handshake. Callers present one unskewed activation vector per cycle and receive one aligned result vector per cycle, so callers no longer do manual skewing or latency bookkeeping. It sits between the activation buffer and the accumulator/requant stage.

Parameters:
IN_WORD_SIZE, 8, activation/weight width (bits)
OUT_WORD_SIZE, 24, partial-sum/result width; must be >= 2*IN_WORD_SIZE
NUM_ROW, 8, PE rows (dot-product length), >= 2
NUM_COL, 8, PE columns (outputs per vector), >= 2
SIGNED, 1, 1 = two's-complement operands, 0 = unsigned

Ports:
clk  in  1  clock, rising edge
reset_n  in  1  asynchronous active-low reset
w_load_valid  in  1  weight-row beat valid; also a reload request while in RUN
w_load_ready  out  1  weight-row beat accepted when high together with w_load_valid
w_row_i  in  IN_WORD_SIZE*NUM_COL  one weight row; column c at [IN_WORD_SIZE*c +: IN_WORD_SIZE]
in_valid  in  1  activation vector valid
in_ready  out  1  activation vector accepted when high together with in_valid
input_i  in  IN_WORD_SIZE*NUM_ROW  activation vector; row r at [IN_WORD_SIZE*r +: IN_WORD_SIZE]
out_valid  out  1  result_o holds one complete result vector
result_o  out  OUT_WORD_SIZE*NUM_COL  column c at [OUT_WORD_SIZE*c +: OUT_WORD_SIZE]

Behaviour:
- Result definition: result[c] = sum over r of input[r]*W[r][c], accumulated modulo 2^OUT_WORD_SIZE. Products are sign- or zero-extended per SIGNED. Wrap is silent; there is no saturation.
- Reset (async, all flops): state=LOAD, w_cnt=0, weights=0, all skew, deskew and pipeline regs=0, out_valid=0, result_o=0. Combinational outputs at reset: w_load_ready=1, in_ready=0.
- FSM states: LOAD, RUN, DRAIN.
- LOAD: w_load_ready=1, in_ready=0.
  - Each handshake writes w_row_i into weight row w_cnt, then increments w_cnt.
  - After beat NUM_ROW-1, w_cnt wraps to 0 and the next state is RUN.
  - The array datapath holds (no enable) while in LOAD.
- RUN: in_ready = !w_load_valid; w_load_ready=0.
  - An accepted vector enters the skew buffer; row r is delayed r cycles.
  - Cycles with no accepted vector inject zeros with valid=0. The array advances every cycle; there is no output backpressure.
  - If w_load_valid is high, go to DRAIN. This takes priority over a simultaneous in_valid, and that input is not accepted.
- DRAIN: in_ready=0, w_load_ready=0.
  - The pipeline keeps advancing using the old weights.
  - When the in-flight counter reaches 0, go to LOAD. A full NUM_ROW-beat reload is mandatory; there is no partial reload.
- PE behaviour: each cycle, activation moves right one PE, and psum_out = psum_in + act*w moves down one PE, both registered. Row 0 psum_in = 0.
- Deskew: column c output is delayed NUM_COL-1-c cycles.
- Latency L = NUM_ROW+NUM_COL-1:
  - A vector accepted at edge t produces out_valid=1 and the full result_o at edge t+L.
  - Back-to-back inputs produce back-to-back outputs with throughput 1 vector/cycle.
- Valid tracking: an L-deep valid shift register drives out_valid. result_o is registered and updates only when out_valid=1; otherwise it holds its last value.
- In-flight counter: range 0..L. +1 on accept, -1 on out_valid, no change when both occur in the same cycle.
- Reset asserted mid-stream: everything in flight is discarded, no out_valid is produced, and the weights must be reloaded.

Decomposition:
- Package systolic_pkg: state enum (LOAD, RUN, DRAIN) and a latency function lat(NUM_ROW, NUM_COL).
- Sub-module pe_mac: one PE holding a weight register, a registered activation pass-through and a registered psum.
  - Ports: clk, reset_n, en, w_we, w_i, act_i, psum_i, act_o, psum_o, parameterised by IN_WORD_SIZE, OUT_WORD_SIZE and SIGNED.
  - The top instantiates a NUM_ROW x NUM_COL grid plus generate-loop skew/deskew shift registers.

Test Plan:
1. Identity weights (W[r][c]=1 iff r==c), input[r]=r+1 accepted at edge t -> out_valid only at edge t+15; result[c]=c+1.
2. SIGNED=1, all W=8'hFF (-1), all input=8'd127 -> every result[c]=24'hFFFC08 (-1016).
3. SIGNED=0, OUT_WORD_SIZE=16, all W=input=8'hFF -> result[c]=16'hF008 (520200 mod 65536, wrap, no saturation).
4. Stream 4 distinct vectors on consecutive cycles, then one 2-cycle gap, then 2 more -> out_valid pattern 1111001 starting at t+15 (out_valid goes high once more after the last 1 shown); each result matches a software golden model; in_ready stays 1 throughout.
5. In RUN with 3 vectors in flight, raise w_load_valid together with in_valid -> that input is not accepted; the 3 results emerge computed with the old weights; state goes LOAD after the last out_valid. After an 8-beat reload, the next vector uses the new weights.
6. Assert reset_n=0 for 1 cycle mid-stream with 5 vectors in flight -> no subsequent out_valid; result_o=0; w_load_ready=1, in_ready=0 until 8 weight beats complete.
